// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating counter plus tag/target per slot,
// trained from decode-stage resolution. Optional BPRED_STATS_EN adds branch/mispredict counters.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic        pred_takenF,
    output logic [31:0] pred_targetF,
    input  logic        upd_valid,
    input  logic        upd_stall,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic [1:0]          cnt_q   [ENTRIES];
    logic                valid_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [31:0]         tgt_q   [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f;
    logic [TAG_BITS-1:0]   tag_f;
    logic                  hit_f;

    logic [INDEX_BITS-1:0] idx_u;
    logic [TAG_BITS-1:0]   tag_u;
    logic                  upd_en;
    logic                  entry_valid_u;
    logic                  tag_match_u;
    logic [1:0]            cnt_cur_u;
    logic [1:0]            cnt_d;
    logic                  cnt_we;
    logic                  entry_we;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcF[1:0], upd_pc[1:0]};

    // Fetch-side lookup; reads the pre-update table contents (no bypass)
    assign idx_f        = pcF[INDEX_BITS+1:2];
    assign tag_f        = pcF[31:INDEX_BITS+2];
    assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_takenF  = hit_f && cnt_q[idx_f][1];
    assign pred_targetF = pred_takenF ? tgt_q[idx_f] : 32'd0;

    assign upd_en        = upd_valid && !upd_stall;
    assign idx_u         = upd_pc[INDEX_BITS+1:2];
    assign tag_u         = upd_pc[31:INDEX_BITS+2];
    assign entry_valid_u = valid_q[idx_u];
    assign tag_match_u   = tag_q[idx_u] == tag_u;
    assign cnt_cur_u     = cnt_q[idx_u];

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = 32'd0;
        if (upd_en) begin
            mispredict = (upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target));
            if (mispredict) begin
                redirect_pc = upd_taken ? upd_target : upd_pc + 32'd8;
            end
        end
    end

    // A taken branch that evicts a foreign entry starts it at weakly-taken
    always_comb begin
        cnt_d = cnt_cur_u;
        if (upd_taken) begin
            if (entry_valid_u && !tag_match_u) begin
                cnt_d = 2'b10;
            end else if (cnt_cur_u != 2'b11) begin
                cnt_d = cnt_cur_u + 2'd1;
            end
        end else if (cnt_cur_u != 2'b00) begin
            cnt_d = cnt_cur_u - 2'd1;
        end
    end

    assign cnt_we   = upd_en && (upd_taken || !entry_valid_u || tag_match_u);
    assign entry_we = upd_en && upd_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i]   <= 2'b01;
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (cnt_we) begin
                cnt_q[idx_u] <= cnt_d;
            end
            if (entry_we) begin
                valid_q[idx_u] <= 1'b1;
            end
        end
    end

    // Tag/target need no reset: they are only observed through valid
    always_ff @(posedge clk) begin
        if (entry_we) begin
            tag_q[idx_u] <= tag_u;
            tgt_q[idx_u] <= upd_target;
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else if (upd_en) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            if (mispredict) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: array-based reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pcF = 32'hBFC0_0010;
    logic        pred_takenF;
    logic [31:0] pred_targetF;
    logic        upd_valid = 1'b0;
    logic        upd_stall = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = 32'd0;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BPRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .pcF             (pcF),
        .pred_takenF     (pred_takenF),
        .pred_targetF    (pred_targetF),
        .upd_valid       (upd_valid),
        .upd_stall       (upd_stall),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
`ifdef BPRED_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-slot counter value 0..3, valid flag, full tag and target
    int          m_cnt   [ENTRIES];
    bit          m_valid [ENTRIES];
    logic [23:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int unsigned m_branches;
    int unsigned m_mispredicts;

    function automatic bit model_mispredict();
        if (!upd_valid || upd_stall) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_cnt[i]   = 1;
                m_valid[i] = 1'b0;
            end
            m_branches    = 0;
            m_mispredicts = 0;
        end else if (upd_valid && !upd_stall) begin
            int  k;
            bit  same;
            k    = int'(upd_pc[7:2]);
            same = m_valid[k] && (m_tag[k] == upd_pc[31:8]);
            m_branches++;
            if (model_mispredict()) m_mispredicts++;
            if (upd_taken) begin
                if (m_valid[k] && !same) m_cnt[k] = 2;
                else if (m_cnt[k] < 3)   m_cnt[k] = m_cnt[k] + 1;
                m_valid[k] = 1'b1;
                m_tag[k]   = upd_pc[31:8];
                m_tgt[k]   = upd_target;
            end else if (!m_valid[k] || same) begin
                if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            int          k;
            bit          e_pt;
            bit          e_mis;
            logic [31:0] e_rd;
            k     = int'(pcF[7:2]);
            e_pt  = m_valid[k] && (m_tag[k] == pcF[31:8]) && (m_cnt[k] >= 2);
            e_mis = model_mispredict();
            e_rd  = !e_mis ? 32'd0 : (upd_taken ? upd_target : upd_pc + 32'd8);
            chk("cyc_pred_taken", {31'd0, pred_takenF}, {31'd0, e_pt});
            chk("cyc_pred_target", pred_targetF, e_pt ? m_tgt[k] : 32'd0);
            chk("cyc_mispredict", {31'd0, mispredict}, {31'd0, e_mis});
            chk("cyc_redirect_pc", redirect_pc, e_rd);
`ifdef BPRED_STATS_EN
            chk("cyc_stat_branches", stat_branches, m_branches);
            chk("cyc_stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif
        end
    end

    task automatic step(input bit v, input bit s, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                        input logic [31:0] pcf);
        @(posedge clk);
        #1;
        upd_valid       = v;
        upd_stall       = s;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        pcF             = pcf;
        #2;
    endtask

    task automatic idle(input logic [31:0] pcf);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, pcf);
    endtask

    task automatic lit(input string name, input bit pt, input logic [31:0] pt_tgt,
                       input bit mis, input logic [31:0] rd);
        chk({name, "_pred_taken"}, {31'd0, pred_takenF}, {31'd0, pt});
        chk({name, "_pred_target"}, pred_targetF, pt_tgt);
        chk({name, "_mispredict"}, {31'd0, mispredict}, {31'd0, mis});
        chk({name, "_redirect"}, redirect_pc, rd);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        lit("reset", 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        idle(32'hBFC0_0010);
        lit("cold_fetch", 1'b0, 32'd0, 1'b0, 32'd0);

        // First taken resolution allocates the slot; same-cycle fetch sees old contents
        step(1, 0, 32'h0040_0020, 1, 32'h0040_0100, 0, 32'd0, 32'h0040_0020);
        lit("alloc", 1'b0, 32'd0, 1'b1, 32'h0040_0100);
        idle(32'h0040_0020);
        lit("after_alloc", 1'b1, 32'h0040_0100, 1'b0, 32'd0);

        step(1, 0, 32'h0040_0020, 1, 32'h0040_0100, 1, 32'h0040_0100, 32'h0040_0020);
        lit("taken2", 1'b1, 32'h0040_0100, 1'b0, 32'd0);
        step(1, 0, 32'h0040_0020, 1, 32'h0040_0100, 1, 32'h0040_0100, 32'h0040_0020);
        lit("taken3_sat", 1'b1, 32'h0040_0100, 1'b0, 32'd0);

        step(1, 0, 32'h0040_0020, 0, 32'd0, 1, 32'h0040_0100, 32'h0040_0020);
        lit("nt1", 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0028);
        step(1, 0, 32'h0040_0020, 0, 32'd0, 0, 32'd0, 32'h0040_0020);
        lit("nt2", 1'b1, 32'h0040_0100, 1'b0, 32'd0);
        idle(32'h0040_0020);
        lit("after_nt2", 1'b0, 32'd0, 1'b0, 32'd0);
        step(1, 0, 32'h0040_0020, 0, 32'd0, 0, 32'd0, 32'h0040_0020);
        step(1, 0, 32'h0040_0020, 0, 32'd0, 0, 32'd0, 32'h0040_0020);
        lit("nt_floor", 1'b0, 32'd0, 1'b0, 32'd0);

        // From the 00 floor two takens are needed to predict taken again
        step(1, 0, 32'h0040_0020, 1, 32'h0040_0100, 0, 32'd0, 32'h0040_0020);
        idle(32'h0040_0020);
        lit("retrain1", 1'b0, 32'd0, 1'b0, 32'd0);
        step(1, 0, 32'h0040_0020, 1, 32'h0040_0100, 0, 32'd0, 32'h0040_0020);
        idle(32'h0040_0020);
        lit("retrain2", 1'b1, 32'h0040_0100, 1'b0, 32'd0);

        step(1, 0, 32'h0040_1020, 1, 32'h0040_2000, 0, 32'd0, 32'h0040_1020);
        lit("alias_res", 1'b0, 32'd0, 1'b1, 32'h0040_2000);
        idle(32'h0040_0020);
        lit("alias_old", 1'b0, 32'd0, 1'b0, 32'd0);
        idle(32'h0040_1020);
        lit("alias_new", 1'b1, 32'h0040_2000, 1'b0, 32'd0);

        step(1, 1, 32'h0040_1020, 0, 32'd0, 1, 32'h0040_2000, 32'h0040_1020);
        lit("stall", 1'b1, 32'h0040_2000, 1'b0, 32'd0);
        idle(32'h0040_1020);
        lit("after_stall", 1'b1, 32'h0040_2000, 1'b0, 32'd0);

        // Not-taken with a foreign tag must leave the slot alone
        step(1, 0, 32'h0040_0020, 0, 32'd0, 0, 32'd0, 32'h0040_1020);
        idle(32'h0040_1020);
        lit("nt_foreign", 1'b1, 32'h0040_2000, 1'b0, 32'd0);
        step(1, 0, 32'h0040_1020, 0, 32'd0, 1, 32'h0040_2000, 32'h0040_1020);
        lit("nt_own", 1'b1, 32'h0040_2000, 1'b1, 32'h0040_1028);
        step(1, 0, 32'h0040_0020, 0, 32'd0, 0, 32'd0, 32'h0040_1020);
        step(1, 0, 32'h0040_1020, 1, 32'h0040_2000, 0, 32'd0, 32'h0040_1020);
        idle(32'h0040_1020);
        lit("nt_foreign2", 1'b1, 32'h0040_2000, 1'b0, 32'd0);

        step(1, 0, 32'h0040_1020, 1, 32'h0040_3000, 1, 32'h0040_2000, 32'h0040_1020);
        lit("tgt_miss", 1'b1, 32'h0040_2000, 1'b1, 32'h0040_3000);
        idle(32'h0040_1020);
        lit("tgt_update", 1'b1, 32'h0040_3000, 1'b0, 32'd0);

        do_reset();
        step(1, 0, 32'h0000_0080, 1, 32'h0000_0200, 0, 32'd0, 32'h0000_0080);
        step(1, 0, 32'h0000_0080, 1, 32'h0000_0200, 1, 32'h0000_0200, 32'h0000_0080);
        step(1, 0, 32'h0000_0080, 1, 32'h0000_0200, 1, 32'h0000_0200, 32'h0000_0080);
        step(1, 0, 32'h0000_0080, 0, 32'd0, 0, 32'd0, 32'h0000_0080);
        step(1, 0, 32'h0000_0080, 1, 32'h0000_0200, 1, 32'h0000_0300, 32'h0000_0080);
        lit("stats_last", 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200);
        idle(32'h0000_0080);
        lit("stats_idle", 1'b1, 32'h0000_0200, 1'b0, 32'd0);
`ifdef BPRED_STATS_EN
        chk("stat_branches_5", stat_branches, 32'd5);
        chk("stat_mispredicts_2", stat_mispredicts, 32'd2);
`endif
        rst = 1'b1;
        #1;
        lit("async_rst", 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef BPRED_STATS_EN
        chk("async_rst_branches", stat_branches, 32'd0);
        chk("async_rst_mispredicts", stat_mispredicts, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        idle(32'h0000_0080);
        lit("post_rst", 1'b0, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
